gate_sweep_engine: RTL



---
 rtl/gate_sweep_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gate_sweep_engine.sv
// Self-sequencing stimulus for an N-input reduction gate: walks all 2^N patterns, HOLD clocks each.
// Define GATE_SWEEP_COUNT_EN to build the ones_count accumulator; otherwise ones_count is tied to 0.
module gate_sweep_engine #(
    parameter int unsigned N    = 4,
    parameter int unsigned HOLD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic [N-1:0] pattern,
    output logic         gate_out,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   mode_q;
    logic [1:0]   mode_d;
    logic [N-1:0] pattern_d;
    logic         gate_d;
    logic         busy_d;
    logic         done_d;
    logic         hold_last;
    logic         accept;
    logic         advance;

    // Gate function applied to a candidate pattern: 00 AND, 01 OR, 10 XOR, 11 NOR.
    function automatic logic reduce(input logic [1:0] m, input logic [N-1:0] p);
        logic r;
        unique case (m)
            2'b00:   r = &p;
            2'b01:   r = |p;
            2'b10:   r = ^p;
            default: r = ~|p;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern;
        gate_d    = gate_out;
        busy_d    = busy;
        done_d    = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_d   = RUN;
                    mode_d    = mode;
                    pattern_d = '0;
                    gate_d    = reduce(mode, '0);
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                if (hold_last) begin
                    advance = 1'b1;
                    if (pattern == '1) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pattern_d = pattern + N'(1);
                        gate_d    = reduce(mode_q, pattern + N'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            pattern  <= '0;
            gate_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pattern  <= pattern_d;
            gate_out <= gate_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Hold counter; with HOLD=1 every RUN cycle advances the pattern.
    generate
        if (HOLD > 1) begin : g_hold
            localparam int unsigned HOLD_W = $clog2(HOLD);
            logic [HOLD_W-1:0] hold_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_q <= '0;
                end else if (accept || advance) begin
                    hold_q <= '0;
                end else if (state_q == RUN) begin
                    hold_q <= hold_q + HOLD_W'(1);
                end
            end

            assign hold_last = (hold_q == HOLD_W'(HOLD - 1));
        end else begin : g_no_hold
            logic unused_hold;
            assign unused_hold = accept ^ advance;
            assign hold_last   = 1'b1;
        end
    endgenerate

`ifdef GATE_SWEEP_COUNT_EN
    localparam int unsigned CNT_W = N + 1;
    logic [CNT_W-1:0] count_q;

    // Accumulates the result of each pattern as it is retired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= '0;
        end else if (advance) begin
            count_q <= count_q + CNT_W'(gate_out);
        end
    end

    assign ones_count = count_q;
`else
    assign ones_count = '0;
`endif

endmodule
